// File: rtl/gru_pkg.sv
// gru_pkg: shared sizes, FSM encoding and element index helper for the matvec stream controller.
package gru_pkg;
  localparam int X = 6;
  localparam int H = 6;
  localparam int DATA_WIDTH = 8;
  localparam int SETTLE_CYCLES = 2;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_SETTLE, S_DRAIN} state_t;
  function automatic int flat_idx(input int m, input int n);
    return m * X + n;
  endfunction
endpackage

// File: rtl/matvec_stream_ctrl_result_serializer.sv
// result_serializer: captures the multiplier outputs once and streams them out over valid/ready.
module result_serializer #(
  parameter int H = gru_pkg::H,
  parameter int DATA_WIDTH = gru_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic                    drain,
  input  logic [0:H*DATA_WIDTH-1] mul_c,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    done
);
  localparam int IW = H > 1 ? $clog2(H) : 1;
  logic [DATA_WIDTH-1:0] res [H];
  logic [IW-1:0] idx;
  logic hs;
  always_comb begin
    m_valid = drain;
    m_last = drain && idx == IW'(H - 1);
    m_data = drain ? res[idx] : '0;
    hs = drain && m_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < H; i++) res[i] <= '0;
      idx <= '0;
      done <= 1'b0;
    end else begin
      if (capture) for (int i = 0; i < H; i++) res[i] <= mul_c[i*DATA_WIDTH +: DATA_WIDTH];
      if (hs) idx <= m_last ? '0 : idx + 1'b1;
      done <= hs && m_last;
    end
  end
endmodule

// File: rtl/matvec_stream_ctrl.sv
// matvec_stream_ctrl: byte-stream loader and result drainer around the combinational 6x6 matrix-vector multiplier.
module matvec_stream_ctrl import gru_pkg::*; #(
  parameter int X = gru_pkg::X,
  parameter int H = gru_pkg::H,
  parameter int DATA_WIDTH = gru_pkg::DATA_WIDTH,
  parameter int SETTLE_CYCLES = gru_pkg::SETTLE_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      reload_w,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic [0:X*H*DATA_WIDTH-1] mat_a,
  output logic [0:X*DATA_WIDTH-1]   vec_b,
  input  logic [0:H*DATA_WIDTH-1]   mul_c,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  output logic                      w_loaded,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(X * H);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic s_hs, w_last, x_last, capture, drain;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (reload_w || !w_loaded) ? S_LOAD_W : S_LOAD_X;
      S_LOAD_W: if (w_last) state_nx = S_LOAD_X;
      S_LOAD_X: if (x_last) state_nx = S_SETTLE;
      S_SETTLE: if (capture) state_nx = S_DRAIN;
      S_DRAIN:  if (m_ready && m_last) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == S_LOAD_W || state == S_LOAD_X;
    busy = state != S_IDLE;
    drain = state == S_DRAIN;
    s_hs = s_ready && s_valid;
    w_last = s_hs && state == S_LOAD_W && cnt == CW'(X * H - 1);
    x_last = s_hs && state == S_LOAD_X && cnt == CW'(X - 1);
    capture = state == S_SETTLE && scnt == '0;
  end
  // mat_a/vec_b only change on LOAD handshakes, so the multiplier inputs are frozen through SETTLE/DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_a <= '0;
      vec_b <= '0;
      w_loaded <= 1'b0;
      cnt <= '0;
      scnt <= '0;
    end else begin
      if (state == S_IDLE && state_nx == S_LOAD_W) w_loaded <= 1'b0;
      if (w_last) w_loaded <= 1'b1;
      if (s_hs && state == S_LOAD_W) mat_a[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
      if (s_hs && state == S_LOAD_X) vec_b[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
      if (s_hs) cnt <= (w_last || x_last) ? '0 : cnt + 1'b1;
      if (x_last) scnt <= SW'(SETTLE_CYCLES - 1);
      else if (state == S_SETTLE && scnt != '0) scnt <= scnt - 1'b1;
    end
  end
  result_serializer #(.H(H), .DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk(clk), .rst(rst), .capture(capture), .drain(drain), .mul_c(mul_c), .m_ready(m_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .done(done)
  );
endmodule

// File: tb/tb_matvec_stream_ctrl.sv
// tb_matvec_stream_ctrl: randomized scoreboard bench with a stand-in multiplier and a matrix-vector reference model.
module tb_matvec_stream_ctrl;
  localparam int X = 6, H = 6, NW = 36;
  logic clk = 0, rst = 1, start = 0, reload_w = 0, s_valid = 0, m_ready = 1;
  logic [7:0] s_data = 0;
  logic [0:NW*8-1] mat_a;
  logic [0:X*8-1] vec_b;
  logic [0:H*8-1] mul_c;
  logic s_ready, m_valid, m_last, w_loaded, busy, done;
  logic [7:0] m_data;
  int errors = 0, checks = 0, cyc = 0, last_s_cyc = 0, pops = 0;
  typedef struct {logic [7:0] d; logic l;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] w_m [NW];
  logic model_wl = 0, use_const = 1, force_stall = 0, rand_ready = 0;
  logic [0:47] stub_const = 48'h112233445566, noise = '0;
  logic pv = 0, pr = 0, pl = 0, exp_done = 0;
  logic [7:0] pd = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matvec_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .reload_w(reload_w), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mat_a(mat_a), .vec_b(vec_b), .mul_c(mul_c), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .w_loaded(w_loaded), .busy(busy), .done(done)
  );

  // stand-in for mult_n_bit6, driven from the DUT buses; noise models c_out moving after capture
  function automatic logic [0:47] stub_mult(input logic [0:NW*8-1] a, input logic [0:47] b);
    logic [0:47] c;
    logic [7:0] acc;
    for (int m = 0; m < H; m++) begin
      acc = 0;
      for (int n = 0; n < X; n++) acc += a[(m*X+n)*8 +: 8] * b[n*8 +: 8];
      c[m*8 +: 8] = acc;
    end
    return c;
  endfunction
  assign mul_c = (use_const ? stub_const : stub_mult(mat_a, vec_b)) ^ noise;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_ready = force_stall ? 1'b0 : rand_ready ? ($urandom_range(3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      exp_done = 0;
    end else begin
      if (s_valid && s_ready) last_s_cyc = cyc;
      if (exp_done || done) chk("done_pulse", done, exp_done);
      exp_done = 0;
      if (m_valid && !pv) chk("latency", cyc - last_s_cyc, 3);
      if (m_valid && pv && !pr) begin
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
          exp_done = e.l;
        end
        pops++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      noise = m_valid ? {$urandom(), 16'($urandom())} : '0;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_w_loaded"}, w_loaded, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mat_a"}, |mat_a, 0);
    chk({tag, "_vec_b"}, |vec_b, 0);
  endtask

  task automatic pulse_start(input logic rl);
    start = 1; reload_w = rl;
    @(posedge clk); #1;
    start = 0; reload_w = 0;
  endtask

  task automatic send(input logic [7:0] d, input int maxgap);
    int t, g;
    g = $urandom_range(maxgap);
    if (g > 0) begin
      s_valid = 0;
      repeat (g) @(posedge clk);
      #1;
    end
    s_valid = 1; s_data = d; t = 0;
    @(negedge clk);
    while (!s_ready && t < 50) begin @(negedge clk); t++; end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic run_txn(input logic rl, input int maxgap, input logic cmode, input logic stall, input logic seq);
    logic [7:0] x [X];
    logic loadw, same;
    int s, t, p0;
    loadw = rl || !model_wl;
    use_const = cmode;
    for (int n = 0; n < X; n++) x[n] = seq ? 8'(n + 1) : 8'($urandom);
    if (loadw) for (int k = 0; k < NW; k++) w_m[k] = seq ? 8'(k) : 8'($urandom);
    for (int m = 0; m < H; m++) begin
      s = 0;
      for (int n = 0; n < X; n++) s += int'(w_m[m*X+n]) * int'(x[n]);
      sb.push_back('{cmode ? stub_const[m*8 +: 8] : 8'(s % 256), m == H - 1});
    end
    pulse_start(rl);
    if (loadw) begin
      for (int k = 0; k < NW; k++) send(w_m[k], maxgap);
      model_wl = 1;
      chk("w_loaded_set", w_loaded, 1);
      chk("load_x_ready", s_ready, 1);
      chk("mat_a_first", mat_a[0 +: 8], w_m[0]);
      chk("mat_a_last", mat_a[280 +: 8], w_m[NW-1]);
    end
    for (int n = 0; n < X; n++) begin
      send(x[n], maxgap);
      if (stall && n == 2) begin
        pulse_start(1);
        chk("start_ign_x_wl", w_loaded, 1);
        chk("start_ign_x_rdy", s_ready, 1);
      end
    end
    chk("s_ready_after_vec", s_ready, 0);
    same = 1;
    for (int k = 0; k < NW; k++) if (mat_a[k*8 +: 8] !== w_m[k]) same = 0;
    for (int n = 0; n < X; n++) if (vec_b[n*8 +: 8] !== x[n]) same = 0;
    chk("operands_held", same, 1);
    if (stall) begin
      p0 = pops; t = 0;
      while (pops < p0 + 2 && t < 200) begin @(negedge clk); t++; end
      chk("drain_progress", pops >= p0 + 2, 1);
      force_stall = 1;
      @(posedge clk); #1;
      pulse_start(1);
      chk("start_ign_drain_v", m_valid, 1);
      chk("start_ign_drain_wl", w_loaded, 1);
      repeat (4) @(posedge clk);
      force_stall = 0;
    end
    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin @(negedge clk); t++; end
    chk("txn_complete", busy || sb.size() != 0, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_reset("rst0");
    run_txn(0, 0, 1, 0, 1);
    run_txn(0, 3, 0, 1, 0);
    rand_ready = 1;
    repeat (5) run_txn(1'($urandom_range(1)), 2, 0, 1'($urandom_range(1)), 0);
    pulse_start(1);
    for (int k = 0; k < 10; k++) send(8'($urandom), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_wl = 0;
    check_reset("rst_mid");
    run_txn(0, 1, 0, 0, 0);
    run_txn(0, 1, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matvec_stream_ctrl.md
Name: matvec_stream_ctrl

Overview:
- Sequential front/back end for the combinational 6x6 approximate matrix-vector multiplier (mult_n_bit6) in the GRU datapath.
- Accepts a byte stream of weights and input-vector elements over valid/ready and assembles the flattened a_in/b_in buses.
- Waits a fixed settle time, captures c_out, then streams the H result bytes out over valid/ready.
- Weights are retained between transactions, so one weight load can serve many vectors.

Parameters:
- X, 6, vector length / matrix columns
- H, 6, matrix rows / result count
- DATA_WIDTH, 8, element width in bits
- SETTLE_CYCLES, 2, cycles between vec_b final update and c_out capture; legal range >= 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transaction; sampled only in IDLE
- reload_w  in  1  sampled with start; 1 = load new weights before the vector
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid&s_ready
- s_data  in  DATA_WIDTH  input element
- mat_a  out  X*H*DATA_WIDTH  drives multiplier a_in; ascending range [0:N-1]
- vec_b  out  X*DATA_WIDTH  drives multiplier b_in; ascending range [0:N-1]
- mul_c  in  H*DATA_WIDTH  multiplier c_out; ascending range [0:N-1]
- m_valid  out  1  result byte valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  result element
- m_last  out  1  high with the H-th result byte
- w_loaded  out  1  a complete weight set is held
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last result handshake

Behaviour:
- Reset: state=IDLE. mat_a=0, vec_b=0, w_loaded=0, s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, all counters=0.
- Rows and columns are indexed m=0..H-1, n=0..X-1. Element index is k = m*X+n.
- Element k of mat_a occupies mat_a[k*DATA_WIDTH +: DATA_WIDTH]. Element 0 is the leftmost/most-significant byte. vec_b and mul_c use the same layout with indices n and m respectively.
- States: IDLE, LOAD_W, LOAD_X, SETTLE, DRAIN.
- IDLE: s_ready=0, m_valid=0.
  - start & (reload_w | !w_loaded) -> LOAD_W.
  - start otherwise -> LOAD_X.
  - start is ignored in every state except IDLE.
- LOAD_W: s_ready=1. Each handshake writes s_data to mat_a element cnt, then cnt++.
  - On the handshake with cnt = X*H-1: set w_loaded=1, clear cnt, go to LOAD_X.
  - w_loaded is cleared on entry to LOAD_W, so a partial load never appears as valid.
- LOAD_X: s_ready=1. Each handshake writes vec_b element cnt.
  - On the handshake with cnt = X-1: clear cnt, load settle counter, go to SETTLE.
- s_valid=0 stalls LOAD_W/LOAD_X indefinitely with no state change.
- SETTLE: s_ready=0. Count SETTLE_CYCLES cycles.
  - On the final cycle, register mul_c into an internal H-entry result buffer, then go to DRAIN.
  - mat_a and vec_b stay stable from entering SETTLE until the next LOAD state.
- DRAIN: m_valid=1, m_data = result[idx], m_last = (idx == H-1).
  - m_data and m_last hold stable while m_ready=0.
  - Each handshake increments idx. On the handshake with idx = H-1: go to IDLE and pulse done for 1 cycle.
- Latency, last input byte accepted to first m_valid: SETTLE_CYCLES+1 cycles.
- The result is independent of mul_c changes after capture.
- start asserted in the same cycle done pulses: accepted only in the following IDLE cycle. done is registered coincident with entry to IDLE, so start on that cycle is taken.
- Reset mid-operation: abort immediately to the reset state. Weights are discarded (w_loaded=0).
- Counters are sized $clog2(X*H) and never wrap past their terminal value.

Decomposition:
- Shared package (gru_pkg):
  - constants X, H, DATA_WIDTH, SETTLE_CYCLES default
  - state enum localparams
  - function flat_idx(m,n) = m*X+n
- One sub-module: result_serializer (H-entry capture buffer + DRAIN valid/ready/last logic), instantiated once.
- mult_n_bit6 is not instantiated inside this block. The top level wires mat_a->a_in, vec_b->b_in, c_out->mul_c.

Test Plan:
- Reset then start=1, reload_w=0 with w_loaded=0 -> enters LOAD_W. After 36 bytes 0x00..0x23: mat_a[0+:8]=0x00, mat_a[280+:8]=0x23, w_loaded=1, state LOAD_X.
- Load vector 0x01..0x06 with bench stub mul_c=0x11223344_5566 -> first m_valid 3 cycles after last s handshake. m_data sequence 0x11,0x22,0x33,0x44,0x55,0x66; m_last only on 0x66; done pulses once.
- Second start with reload_w=0 -> goes straight to LOAD_X, s_ready for exactly 6 handshakes, mat_a unchanged.
- Randomized s_valid gaps and m_ready held low for 5 cycles mid-DRAIN -> no lost or duplicated bytes; m_data stable while stalled. Change mul_c during DRAIN -> output unaffected.
- Assert start during LOAD_X and DRAIN -> ignored, no state change.
- rst during LOAD_W after 10 bytes -> all outputs at reset values next cycle, w_loaded=0. Next start (reload_w=0) enters LOAD_W.
